// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operand/opcode types, arbiter state encoding and latency limits
package alu_pkg;

    typedef logic [7:0] data_t;

    typedef enum logic [1:0] {
        OP1 = 2'd0,
        OP2 = 2'd1,
        OP3 = 2'd2,
        OP4 = 2'd3
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        CLEAR
    } arb_state_t;

    localparam int ALU_LAT_MAX = 15;
    localparam int CNT_W       = $clog2(ALU_LAT_MAX + 1);

endpackage

// File: rtl/alu_port_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin grant; the last-grant pointer moves only on accept
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_b_q;
    logic last_b_d;

    // A lone requester always wins; on a tie the one not granted last wins
    always_comb begin
        gnt_a    = req_a && (!req_b || last_b_q);
        gnt_b    = req_b && (!req_a || !last_b_q);
        last_b_d = accept ? gnt_b : last_b_q;
    end

    // Pointer starts at B so that A wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_b_q <= 1'b1;
        else        last_b_q <= last_b_d;
    end

endmodule

// File: rtl/alu_port_arbiter.sv
// alu_port_arbiter: round-robin sequencer sharing the ALU between requesters A and B (option: ALU_ARB_IRQ_AUTOCLR_EN)
module alu_port_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       alu_rst,
    input  logic       a_req_valid,
    output logic       a_req_ready,
    input  data_t      a_req_x,
    input  data_t      a_req_y,
    input  opcode_t    a_req_op,
    output logic       a_rsp_valid,
    output logic [7:0] a_rsp_data,
    output logic       a_rsp_irq,
    input  logic       b_req_valid,
    output logic       b_req_ready,
    input  data_t      b_req_x,
    input  data_t      b_req_y,
    input  opcode_t    b_req_op,
    output logic       b_rsp_valid,
    output logic [7:0] b_rsp_data,
    output logic       b_rsp_irq,
    output data_t      alu_in_a,
    output data_t      alu_in_b,
    output opcode_t    alu_op_a,
    output opcode_t    alu_op_b,
    output logic       alu_enable,
    output logic       alu_enable_a,
    output logic       alu_enable_b,
    output logic       alu_irq_clr,
    input  logic [7:0] alu_out,
    input  logic       alu_irq,
    output logic       busy
);

`ifdef ALU_ARB_IRQ_AUTOCLR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_b_q, gnt_b_d;
    data_t            in_a_q, in_a_d, in_b_q, in_b_d;
    opcode_t          op_a_q, op_a_d, op_b_q, op_b_d;
    logic             en_q, en_d, en_a_q, en_a_d, en_b_q, en_b_d, clr_q, clr_d;
    logic             a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [7:0]       a_dat_q, a_dat_d, b_dat_q, b_dat_d;
    logic             a_irq_q, a_irq_d, b_irq_q, b_irq_d;
    logic             gnt_a, gnt_b, acc_a, acc_b, cap, go_clr;

    rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (alu_rst),
        .req_a  (a_req_valid),
        .req_b  (b_req_valid),
        .accept (acc_a || acc_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    assign acc_a        = (state_q == IDLE) && gnt_a;
    assign acc_b        = (state_q == IDLE) && gnt_b;
    assign a_req_ready  = acc_a;
    assign b_req_ready  = acc_b;
    assign busy         = state_q != IDLE;
    assign alu_in_a     = in_a_q;
    assign alu_in_b     = in_b_q;
    assign alu_op_a     = op_a_q;
    assign alu_op_b     = op_b_q;
    assign alu_enable   = en_q;
    assign alu_enable_a = en_a_q;
    assign alu_enable_b = en_b_q;
    assign alu_irq_clr  = clr_q;
    assign a_rsp_valid  = a_vld_q;
    assign a_rsp_data   = a_dat_q;
    assign a_rsp_irq    = a_irq_q;
    assign b_rsp_valid  = b_vld_q;
    assign b_rsp_data   = b_dat_q;
    assign b_rsp_irq    = b_irq_q;

    // Next-state, operand latch on accept, enable pulse and response capture
    always_comb begin
        cap     = state_q == CAPTURE;
        go_clr  = AUTOCLR && cap && alu_irq;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    state_d = (acc_a || acc_b) ? ISSUE : IDLE;
            ISSUE: begin
                state_d = (ALU_LAT > 1) ? WAIT : CAPTURE;
                cnt_d   = CNT_W'(ALU_LAT - 1);
            end
            WAIT: begin
                state_d = (cnt_q == CNT_W'(1)) ? CAPTURE : WAIT;
                cnt_d   = cnt_q - 1'b1;
            end
            CAPTURE: state_d = go_clr ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
        gnt_b_d = (acc_a || acc_b) ? acc_b : gnt_b_q;
        in_a_d  = acc_a ? a_req_x : acc_b ? b_req_x : in_a_q;
        in_b_d  = acc_a ? a_req_y : acc_b ? b_req_y : in_b_q;
        op_a_d  = acc_a ? a_req_op : op_a_q;
        op_b_d  = acc_b ? b_req_op : op_b_q;
        en_d    = acc_a || acc_b;
        en_a_d  = acc_a;
        en_b_d  = acc_b;
        clr_d   = go_clr;
        a_vld_d = cap && !gnt_b_q;
        b_vld_d = cap && gnt_b_q;
        a_dat_d = a_vld_d ? alu_out : a_dat_q;
        b_dat_d = b_vld_d ? alu_out : b_dat_q;
        a_irq_d = a_vld_d ? alu_irq : a_irq_q;
        b_irq_d = b_vld_d ? alu_irq : b_irq_q;
    end

    // All state and outputs registered; reset drops any transaction in flight
    always_ff @(posedge clk or negedge alu_rst) begin
        if (!alu_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_b_q <= 1'b0;
            in_a_q  <= '0;
            in_b_q  <= '0;
            op_a_q  <= OP1;
            op_b_q  <= OP1;
            en_q    <= 1'b0;
            en_a_q  <= 1'b0;
            en_b_q  <= 1'b0;
            clr_q   <= 1'b0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            a_dat_q <= '0;
            b_dat_q <= '0;
            a_irq_q <= 1'b0;
            b_irq_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_b_q <= gnt_b_d;
            in_a_q  <= in_a_d;
            in_b_q  <= in_b_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            en_q    <= en_d;
            en_a_q  <= en_a_d;
            en_b_q  <= en_b_d;
            clr_q   <= clr_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            a_dat_q <= a_dat_d;
            b_dat_q <= b_dat_d;
            a_irq_q <= a_irq_d;
            b_irq_q <= b_irq_d;
        end
    end

endmodule

// File: tb/tb_alu_port_arbiter.sv
// tb_alu_port_arbiter: two arbiters (latency 1 and 4) checked per cycle against a transaction-level model
module tb_alu_port_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic alu_rst = 1'b1;
    always #5 clk = ~clk;

    logic       v   [2][2];
    data_t      x   [2][2];
    data_t      y   [2][2];
    opcode_t    op  [2][2];
    logic [1:0] rdy [2];
    logic [1:0] rv  [2];
    logic [1:0] ri  [2];
    data_t      rd  [2][2];
    data_t      in_a [2];
    data_t      in_b [2];
    opcode_t    opa [2];
    opcode_t    opb [2];
    logic [1:0] en, ena, enb, clr, bsy;
    data_t      alu_o;
    logic       alu_i;

    for (genvar g = 0; g < 2; g++) begin : dut
        alu_port_arbiter #(.ALU_LAT(g == 0 ? 1 : 4)) u (
            .clk          (clk),
            .alu_rst      (alu_rst),
            .a_req_valid  (v[g][0]),
            .a_req_ready  (rdy[g][0]),
            .a_req_x      (x[g][0]),
            .a_req_y      (y[g][0]),
            .a_req_op     (op[g][0]),
            .a_rsp_valid  (rv[g][0]),
            .a_rsp_data   (rd[g][0]),
            .a_rsp_irq    (ri[g][0]),
            .b_req_valid  (v[g][1]),
            .b_req_ready  (rdy[g][1]),
            .b_req_x      (x[g][1]),
            .b_req_y      (y[g][1]),
            .b_req_op     (op[g][1]),
            .b_rsp_valid  (rv[g][1]),
            .b_rsp_data   (rd[g][1]),
            .b_rsp_irq    (ri[g][1]),
            .alu_in_a     (in_a[g]),
            .alu_in_b     (in_b[g]),
            .alu_op_a     (opa[g]),
            .alu_op_b     (opb[g]),
            .alu_enable   (en[g]),
            .alu_enable_a (ena[g]),
            .alu_enable_b (enb[g]),
            .alu_irq_clr  (clr[g]),
            .alu_out      (alu_o),
            .alu_irq      (alu_i),
            .busy         (bsy[g])
        );
    end

    // Reference model: each accepted transaction is a set of scheduled cycle numbers
    int      cyc, passed, total, failed, mode;
    int      iss [2], cap [2], rspc [2], clrc [2], free_at [2], gr [2], rg [2];
    logic    last_b [2];
    logic    acc [2][2];
    data_t   e_in_a [2], e_in_b [2], e_rd [2];
    logic    e_ri [2];
    opcode_t e_opa [2], e_opb [2];

    function automatic int lat(int k);
        return k == 0 ? 1 : 4;
    endfunction

    task automatic ck(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            iss[k] = -1; cap[k] = -1; rspc[k] = -1; clrc[k] = -1; free_at[k] = 0;
            gr[k] = 0; rg[k] = 0; last_b[k] = 1'b1;
            e_in_a[k] = '0; e_in_b[k] = '0; e_opa[k] = OP1; e_opb[k] = OP1;
            e_rd[k] = '0; e_ri[k] = 1'b0;
            acc[k][0] = 1'b0; acc[k][1] = 1'b0;
        end
    endtask

    task automatic check_reset(int k);
        ck("rst_ready", k, rdy[k], 0);
        ck("rst_rsp_valid", k, rv[k], 0);
        ck("rst_rsp_irq", k, ri[k], 0);
        ck("rst_rsp_data_a", k, rd[k][0], 0);
        ck("rst_rsp_data_b", k, rd[k][1], 0);
        ck("rst_in_a", k, in_a[k], 0);
        ck("rst_in_b", k, in_b[k], 0);
        ck("rst_op_a", k, opa[k], OP1);
        ck("rst_op_b", k, opb[k], OP1);
        ck("rst_enables", k, {en[k], ena[k], enb[k]}, 0);
        ck("rst_irq_clr", k, clr[k], 0);
        ck("rst_busy", k, bsy[k], 0);
    endtask

    task automatic check_regs(int k);
        ck("enable", k, en[k], cyc == iss[k]);
        ck("enable_a", k, ena[k], cyc == iss[k] && gr[k] == 0);
        ck("enable_b", k, enb[k], cyc == iss[k] && gr[k] == 1);
        ck("busy", k, bsy[k], cyc < free_at[k]);
        ck("irq_clr", k, clr[k], cyc == clrc[k]);
        ck("alu_in_a", k, in_a[k], e_in_a[k]);
        ck("alu_in_b", k, in_b[k], e_in_b[k]);
        ck("alu_op_a", k, opa[k], e_opa[k]);
        ck("alu_op_b", k, opb[k], e_opb[k]);
        for (int r = 0; r < 2; r++) begin
            ck("rsp_valid", k, rv[k][r], cyc == rspc[k] && rg[k] == r);
            if (cyc == rspc[k] && rg[k] == r) begin
                ck("rsp_data", k, rd[k][r], e_rd[k]);
                ck("rsp_irq", k, ri[k][r], e_ri[k]);
            end
        end
    endtask

    task automatic new_req(int k, int r);
        v[k][r]  = 1'b1;
        x[k][r]  = data_t'($urandom);
        y[k][r]  = data_t'($urandom);
        op[k][r] = opcode_t'($urandom_range(0, 3));
    endtask

    task automatic drive(int k, int r);
        if (acc[k][r]) v[k][r] = 1'b0;
        acc[k][r] = 1'b0;
        if (mode == 1 && !v[k][r]) new_req(k, r);
        else if (mode == 2) begin
            if (v[k][r] && $urandom_range(0, 15) == 0) v[k][r] = 1'b0;
            else if (!v[k][r] && $urandom_range(0, 2) == 0) new_req(k, r);
        end
    endtask

    task automatic step_a();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) check_regs(k);
        for (int k = 0; k < 2; k++) for (int r = 0; r < 2; r++) drive(k, r);
        alu_o = data_t'($urandom);
        alu_i = 1'($urandom_range(0, 1));
    endtask

    task automatic step_b();
        #1;
        for (int k = 0; k < 2; k++) begin
            logic idle, ga, gb;
            int   r;
            if (cyc == cap[k]) begin
                e_rd[k] = alu_o;
                e_ri[k] = alu_i;
                rg[k]   = gr[k];
                rspc[k] = cyc + 1;
`ifdef ALU_ARB_IRQ_AUTOCLR_EN
                if (alu_i) begin
                    clrc[k]    = cyc + 1;
                    free_at[k] = cyc + 2;
                end
`endif
            end
            idle = cyc >= free_at[k];
            ga   = idle && v[k][0] && (!v[k][1] || last_b[k]);
            gb   = idle && v[k][1] && (!v[k][0] || !last_b[k]);
            ck("ready_a", k, rdy[k][0], ga);
            ck("ready_b", k, rdy[k][1], gb);
            if (ga || gb) begin
                r          = gb ? 1 : 0;
                acc[k][r]  = 1'b1;
                last_b[k]  = gb;
                gr[k]      = r;
                iss[k]     = cyc + 1;
                cap[k]     = cyc + 1 + lat(k);
                free_at[k] = cyc + 2 + lat(k);
                e_in_a[k]  = x[k][r];
                e_in_b[k]  = y[k][r];
                if (r == 0) e_opa[k] = op[k][0];
                else        e_opb[k] = op[k][1];
            end
        end
    endtask

    task automatic step();
        step_a();
        step_b();
    endtask

    task automatic clear_valids();
        for (int k = 0; k < 2; k++) for (int r = 0; r < 2; r++) begin
            v[k][r] = 1'b0; x[k][r] = '0; y[k][r] = '0; op[k][r] = OP1;
        end
    endtask

    initial begin
        cyc = 0; passed = 0; total = 0; failed = 0; mode = 0;
        alu_o = '0; alu_i = 1'b0;
        clear_valids();
        model_reset();
        #2 alu_rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check_reset(k);
        @(posedge clk);
        @(posedge clk);
        #2 alu_rst = 1'b1;
        // Single A request: x=0F, y=01, OP1
        step_a();
        for (int k = 0; k < 2; k++) begin
            v[k][0] = 1'b1; x[k][0] = 8'h0F; y[k][0] = 8'h01; op[k][0] = OP1;
        end
        step_b();
        repeat (10) step();
        // Simultaneous A and B, then both held valid so grants alternate
        step_a();
        for (int k = 0; k < 2; k++) begin
            new_req(k, 0);
            new_req(k, 1);
        end
        step_b();
        mode = 1;
        repeat (40) step();
        // Random traffic with random ALU results and interrupts
        mode = 2;
        repeat (3000) step();
        mode = 0;
        repeat (40) step();
        // Reset while the latency-4 instance sits in WAIT
        step_a();
        for (int k = 0; k < 2; k++) new_req(k, 0);
        step_b();
        repeat (3) step();
        clear_valids();
        #1 alu_rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) check_reset(k);
        model_reset();
        repeat (2) step();
        alu_rst = 1'b1;
        // First tie after reset goes to A
        step_a();
        for (int k = 0; k < 2; k++) begin
            new_req(k, 0);
            new_req(k, 1);
        end
        step_b();
        mode = 1;
        repeat (20) step();
        mode = 0;
        repeat (30) step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_port_arbiter.md
# alu_port_arbiter

Sequencer that shares the dual-mode ALU between two independent requesters, A and B. Each requester issues an operand pair plus opcode over a valid/ready handshake. The arbiter grants one request at a time with round-robin priority and drives the ALU inputs and enables. It waits a fixed latency, captures `alu_out`/`alu_irq`, returns the result to the granted requester and optionally clears the interrupt. It sits directly between the requester-side agents and the ALU ports.

## Interface
Parameters:
- `ALU_LAT`, 1: cycles from the enable-issue cycle to the cycle in which `alu_out`/`alu_irq` are valid; legal range 1..15.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `alu_rst` in 1: reset, asynchronous, active-low.
- `a_req_valid` in 1: requester A has a request.
- `a_req_ready` out 1: arbiter accepts A this cycle.
- `a_req_x`, `a_req_y` in `data_t` (8): operands.
- `a_req_op` in `opcode_t`: operation, driven to `alu_op_a`.
- `a_rsp_valid` out 1: one-cycle result pulse.
- `a_rsp_data` out 8: result.
- `a_rsp_irq` out 1: `alu_irq` value captured with the result.
- `b_*`: identical set for requester B; `b_req_op` is driven to `alu_op_b`.
- `alu_in_a`, `alu_in_b` out `data_t`: operand x and operand y.
- `alu_op_a`, `alu_op_b` out `opcode_t`.
- `alu_enable`, `alu_enable_a`, `alu_enable_b` out 1.
- `alu_irq_clr` out 1.
- `alu_out` in 8.
- `alu_irq` in 1.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, CLEAR.
- IDLE:
  - `*_req_ready` is high only in IDLE and only for the granted requester, computed combinationally from the valids.
  - Both valid: grant the requester not granted last.
  - One valid: grant it.
  - The last-grant pointer resets to B, so A wins the first tie.
- Accept (valid && ready): register x, y and opcode into the ALU-side output registers, record the grant, go to ISSUE.
  - The non-granted opcode output holds its previous value.
- ISSUE (exactly 1 cycle): `alu_enable`=1 plus exactly one of `alu_enable_a`/`alu_enable_b` per grant.
  - All three enables are high together in no state.
  - Next state is WAIT if `ALU_LAT`>1, otherwise CAPTURE.
- WAIT: enables low; a down-counter loaded with `ALU_LAT`-1 on entry; go to CAPTURE when it reaches 1.
- CAPTURE: sample `alu_out`/`alu_irq` into the granted requester's rsp registers.
- Next cycle: that requester's `rsp_valid` pulses high for 1 cycle. There is no response backpressure.
- After CAPTURE: go to CLEAR if the captured irq is 1 and the macro is defined, otherwise IDLE.
- CLEAR: `alu_irq_clr`=1 for exactly 1 cycle, then IDLE.
- Operand and opcode outputs hold their values outside accept cycles, so ALU inputs stay stable while the ALU is idle.
- Reset values: every output 0, opcode outputs `OP1`, FSM IDLE, pointer B, counter 0.
- Reset asserted mid-operation: the transaction is dropped, no `rsp_valid` is produced, and the requester must re-issue.

## Timing
- Accept at cycle t.
- ISSUE at t+1.
- Capture at t+1+`ALU_LAT`.
- `rsp_valid` at t+2+`ALU_LAT`.
- Next accept no earlier than t+2+`ALU_LAT` when there is no CLEAR, or t+3+`ALU_LAT` with CLEAR.
- `rsp_valid` of one transaction may coincide with `req_ready` of the next.
- A request arriving during `busy` waits, and its valid must hold until accepted.
- A requester dropping valid before acceptance is legal; no grant is recorded.

## Configuration
- `ALU_ARB_IRQ_AUTOCLR_EN` defined:
  - The CLEAR state exists.
  - Any transaction that captures `alu_irq`=1 is followed by a one-cycle `alu_irq_clr` pulse.
- Undefined:
  - CLEAR is removed and `alu_irq_clr` is tied 0.
  - `*_rsp_irq` is still reported; clearing is left to system software.

## Structure
- `alu_pkg` holds:
  - `data_t` and `opcode_t` (existing);
  - a new `arb_state_t` enum (IDLE, ISSUE, WAIT, CAPTURE, CLEAR);
  - `ALU_LAT_MAX` = 15.
- One sub-module, `rr_arb2`: a two-requester round-robin grant with the last-grant pointer, updated only on accept.
- The FSM, counter and datapath registers stay in the top.

## Test plan
- Single A request, x=8'h0F, y=8'h01, op OP1, `ALU_LAT`=1 → `alu_enable`=`alu_enable_a`=1 for one cycle at t+1; `a_rsp_valid` at t+3 carries `alu_out`; `b_rsp_valid` stays 0.
- A and B valid in the same IDLE cycle after reset → A granted first, B accepted at the next IDLE. Repeat with both held valid → grants alternate A, B, A, B.
- `ALU_LAT`=4 → enables high for exactly 1 cycle; `rsp_valid` at t+6; `busy` high from t+1 to t+5.
- Macro defined, ALU returns `alu_irq`=1 → `a_rsp_irq`=1 and `alu_irq_clr` pulses for 1 cycle after the capture cycle. Macro undefined → `alu_irq_clr` stays 0 throughout.
- Reset asserted during WAIT → all outputs 0 and opcodes `OP1` immediately (asynchronously); no `rsp_valid`; the first post-reset tie goes to A.
- Continuous random traffic → never all three enables high; `alu_enable_a` and `alu_enable_b` never high together.
